// File: rtl/sc_spi_hsctl_if.sv
// rtl/sc_spi_hsctl_if.sv - handshake bundle between the SPI transfer requester and sc_spi_hsctl
// Signals:
//   START, ABORT, ERRCLR, SPIBUSY_SYSCLK : requester/engine -> controller
//   CLKEN, BUSY, DONE, TIMEOUT, TOUT_STS : controller -> requester/engine
// Modports: master (requester side), slave (controller side)
interface sc_spi_hsctl_if;
    logic START;
    logic ABORT;
    logic ERRCLR;
    logic SPIBUSY_SYSCLK;
    logic CLKEN;
    logic BUSY;
    logic DONE;
    logic TIMEOUT;
    logic TOUT_STS;

    modport master (
        output START, ABORT, ERRCLR, SPIBUSY_SYSCLK,
        input  CLKEN, BUSY, DONE, TIMEOUT, TOUT_STS
    );

    modport slave (
        input  START, ABORT, ERRCLR, SPIBUSY_SYSCLK,
        output CLKEN, BUSY, DONE, TIMEOUT, TOUT_STS
    );
endinterface

// File: rtl/sc_spi_hsctl.sv
// rtl/sc_spi_hsctl.sv - SYSCLK-domain handshake controller for the SPI protocol engine
// Optional feature macro: SC_SPI_HSCTL_TIMEOUT_EN (acknowledge timeout, TIMEOUT, TOUT_STS, ERRCLR)
// Ports:
//   SYSCLK  : system clock, rising edge
//   SYSRSTB : asynchronous active-low reset
//   bus     : slave modport; START/ABORT/ERRCLR/SPIBUSY_SYSCLK in,
//             CLKEN/BUSY/DONE/TIMEOUT/TOUT_STS out (all registered)
module sc_spi_hsctl #(
    parameter int unsigned ACK_TIMEOUT  = 255,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic          SYSCLK,
    input  logic          SYSRSTB,
    sc_spi_hsctl_if.slave bus
);
    localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_STOP,
        S_GUARD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        done_d;
    logic        clken_q;
    logic        busy_q;
    logic        done_q;
    logic        spibusy;

`ifdef SC_SPI_HSCTL_TIMEOUT_EN
    logic        tout_d;
    logic        tout_q;
    logic        tout_sts_q;
`endif

    assign spibusy = bus.SPIBUSY_SYSCLK;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SC_SPI_HSCTL_TIMEOUT_EN
        tout_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A busy flag still high from a previous transfer blocks the request.
                if (bus.START && !bus.ABORT && !spibusy) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                // Busy is checked first so an acknowledge in the timeout cycle wins.
                if (spibusy) begin
                    state_d = bus.ABORT ? S_STOP : S_RUN;
                end else if (bus.ABORT) begin
                    state_d = S_GUARD;
`ifdef SC_SPI_HSCTL_TIMEOUT_EN
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_GUARD;
                    tout_d  = 1'b1;
`endif
                end
            end
            S_RUN: begin
                if (!spibusy) begin
                    state_d = S_GUARD;
                    done_d  = 1'b1;
                end else if (bus.ABORT) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!spibusy) begin
                    state_d = S_GUARD;
                    done_d  = 1'b1;
                end
            end
            S_GUARD: begin
                // A late busy rise (engine acknowledged after a timeout) restarts the interval.
                if (spibusy) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == GUARD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The shared counter always starts from zero in a newly entered state.
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            clken_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clken_q <= (state_d == S_REQ) || (state_d == S_RUN);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
        end
    end

    assign bus.CLKEN = clken_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;

`ifdef SC_SPI_HSCTL_TIMEOUT_EN
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            tout_q     <= 1'b0;
            tout_sts_q <= 1'b0;
        end else begin
            tout_q <= tout_d;
            // Setting has priority over a simultaneous clear.
            if (tout_d) begin
                tout_sts_q <= 1'b1;
            end else if (bus.ERRCLR) begin
                tout_sts_q <= 1'b0;
            end
        end
    end

    assign bus.TIMEOUT  = tout_q;
    assign bus.TOUT_STS = tout_sts_q;
`else
    logic unused_cfg;
    assign unused_cfg   = ^{bus.ERRCLR, ACK_LAST};
    assign bus.TIMEOUT  = 1'b0;
    assign bus.TOUT_STS = 1'b0;
`endif
endmodule

// File: tb/tb_sc_spi_hsctl.sv
// tb/tb_sc_spi_hsctl.sv - self-checking bench for sc_spi_hsctl against per-transaction expected timelines
module tb_sc_spi_hsctl;
    localparam int ACK  = 8;
    localparam int G    = 4;
    localparam int MAXN = 1100;

    logic SYSCLK = 1'b0;
    logic SYSRSTB;

    sc_spi_hsctl_if bus ();

    sc_spi_hsctl #(.ACK_TIMEOUT(ACK), .GUARD_CYCLES(G)) dut (
        .SYSCLK (SYSCLK),
        .SYSRSTB(SYSRSTB),
        .bus    (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int errors = 0;
    bit sts_model = 1'b0;
    int n;

    // Stimulus per relative cycle (cycle 0 = the START sampling edge).
    bit i_start [MAXN];
    bit i_abort [MAXN];
    bit i_busy  [MAXN];
    bit i_errclr[MAXN];
    // Expected outputs per relative cycle.
    bit x_clken [MAXN+1];
    bit x_busy  [MAXN+1];
    bit x_done  [MAXN+1];
    bit x_tout  [MAXN+1];
    bit x_sts   [MAXN+1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_txn();
        for (int c = 0; c < MAXN; c++) begin
            i_start[c] = 0; i_abort[c] = 0; i_busy[c] = 0; i_errclr[c] = 0;
        end
        for (int c = 0; c <= MAXN; c++) begin
            x_clken[c] = 0; x_busy[c] = 0; x_done[c] = 0; x_tout[c] = 0; x_sts[c] = 0;
        end
    endtask

    // Engine acknowledges at cycle d, drops busy at f=d+l; optional ABORT at d+k_off.
    task automatic build_normal(input int d, input int l, input bit abort_run, input int k_off, input int gap);
        int f;
        int kill;
        clear_txn();
        f    = d + l;
        kill = abort_run ? d + k_off : f;
        i_start[0] = 1;
        i_start[1 + $urandom_range(0, 2)] = 1;
        for (int c = d; c < f; c++) i_busy[c] = 1;
        if (abort_run) i_abort[kill] = 1;
        for (int c = 1; c <= kill; c++) x_clken[c] = 1;
        x_done[f + 1] = 1;
        for (int c = 1; c <= f + G; c++) x_busy[c] = 1;
        n = f + G + 1 + gap;
        i_errclr[n - 1] = 1'($urandom_range(0, 1));
    endtask

    // ABORT while still waiting for the acknowledge.
    task automatic build_abort_req(input int k, input int gap);
        clear_txn();
        i_start[0] = 1;
        i_abort[k] = 1;
        for (int c = 1; c <= k; c++) x_clken[c] = 1;
        for (int c = 1; c <= k + G; c++) x_busy[c] = 1;
        n = k + G + 1 + gap;
    endtask

    // No acknowledge: CLKEN for ACK cycles, then GUARD, optionally stretched by a late busy pulse.
    task automatic build_timeout(input bit late, input int a, input int b, input bit clr_same, input int gap);
        int last;
        int s;
        clear_txn();
        i_start[0] = 1;
        for (int c = 1; c <= ACK; c++) x_clken[c] = 1;
        x_tout[ACK + 1] = 1;
        if (clr_same) i_errclr[ACK] = 1;
        last = ACK + G;
        if (late) begin
            s = ACK + 1 + a;
            for (int c = s; c < s + b; c++) i_busy[c] = 1;
            last = s + b - 1 + G;
        end
        for (int c = 1; c <= last; c++) x_busy[c] = 1;
        n = last + 1 + gap;
        i_errclr[n - 1] = 1'($urandom_range(0, 1));
    endtask

    // Requests that must be dropped in IDLE.
    task automatic build_ignored(input bit mode);
        clear_txn();
        if (mode == 1'b0) begin
            for (int c = 0; c <= 2; c++) i_busy[c] = 1;
            i_start[0] = 1;
            i_start[2] = 1;
        end else begin
            i_start[0] = 1;
            i_abort[0] = 1;
        end
        n = 5;
    endtask

    task automatic drive_idle();
        bus.START = 0; bus.ABORT = 0; bus.ERRCLR = 0; bus.SPIBUSY_SYSCLK = 0;
    endtask

    task automatic run_txn(input string name, input int upto);
        x_sts[0] = sts_model;
        for (int r = 0; r < n; r++) begin
`ifdef SC_SPI_HSCTL_TIMEOUT_EN
            x_sts[r + 1] = x_tout[r + 1] ? 1'b1 : (i_errclr[r] ? 1'b0 : x_sts[r]);
`else
            x_sts[r + 1] = 1'b0;
`endif
        end
        for (int r = 0; r < upto; r++) begin
            @(negedge SYSCLK);
            check($sformatf("%s clken@%0d", name, r), 32'(bus.CLKEN), 32'(x_clken[r]));
            check($sformatf("%s busy@%0d", name, r), 32'(bus.BUSY), 32'(x_busy[r]));
            check($sformatf("%s done@%0d", name, r), 32'(bus.DONE), 32'(x_done[r]));
            check($sformatf("%s timeout@%0d", name, r), 32'(bus.TIMEOUT), 32'(x_tout[r]));
            check($sformatf("%s tout_sts@%0d", name, r), 32'(bus.TOUT_STS), 32'(x_sts[r]));
            bus.START          = i_start[r];
            bus.ABORT          = i_abort[r];
            bus.SPIBUSY_SYSCLK = i_busy[r];
            bus.ERRCLR         = i_errclr[r];
        end
        sts_model = x_sts[upto];
    endtask

    task automatic check_all_zero(input string name);
        check({name, " clken"}, 32'(bus.CLKEN), 32'd0);
        check({name, " busy"}, 32'(bus.BUSY), 32'd0);
        check({name, " done"}, 32'(bus.DONE), 32'd0);
        check({name, " timeout"}, 32'(bus.TIMEOUT), 32'd0);
        check({name, " tout_sts"}, 32'(bus.TOUT_STS), 32'd0);
    endtask

    initial begin
        int kind;
        int d;
        int l;
        SYSRSTB = 1'b0;
        drive_idle();
        repeat (3) @(negedge SYSCLK);
        check_all_zero("reset");
        SYSRSTB = 1'b1;

        build_normal(5, 15, 1'b0, 0, 2);
        run_txn("normal", n);
        build_normal(5, 10, 1'b1, 5, 1);
        run_txn("abort_run", n);
        build_abort_req(3, 1);
        run_txn("abort_req", n);
        build_ignored(1'b0);
        run_txn("stale_busy", n);
        build_ignored(1'b1);
        run_txn("start_abort", n);
`ifdef SC_SPI_HSCTL_TIMEOUT_EN
        build_timeout(1'b0, 0, 0, 1'b0, 2);
        run_txn("timeout", n);
        build_timeout(1'b0, 0, 0, 1'b1, 2);
        run_txn("timeout_clr", n);
        build_normal(ACK, 4, 1'b0, 0, 1);
        run_txn("ack_at_limit", n);
        build_timeout(1'b1, 2, 3, 1'b0, 1);
        run_txn("late_busy", n);
`else
        build_abort_req(1000, 1);
        run_txn("no_timeout", n);
`endif

        // Asynchronous reset in the middle of RUN.
        build_normal(2, 10, 1'b0, 0, 0);
        run_txn("pre_reset", 6);
        @(posedge SYSCLK);
        #2;
        SYSRSTB = 1'b0;
        drive_idle();
        #1;
        check_all_zero("async_reset");
        @(negedge SYSCLK);
        SYSRSTB = 1'b1;
        sts_model = 1'b0;
        build_normal(3, 6, 1'b0, 0, 1);
        run_txn("post_reset", n);

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 4);
            d    = $urandom_range(1, ACK);
            l    = $urandom_range(1, 12);
            case (kind)
                0: build_normal(d, l, 1'b0, 0, $urandom_range(0, 2));
                1: build_normal(d, l, 1'b1, $urandom_range(0, l - 1), $urandom_range(0, 2));
                2: build_abort_req($urandom_range(1, ACK - 1), $urandom_range(0, 2));
`ifdef SC_SPI_HSCTL_TIMEOUT_EN
                3: build_timeout(1'($urandom_range(0, 1)), $urandom_range(0, G - 1),
                                 $urandom_range(1, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
`else
                3: build_abort_req($urandom_range(ACK, 40), $urandom_range(0, 2));
`endif
                default: build_ignored(1'($urandom_range(0, 1)));
            endcase
            run_txn($sformatf("rand%0d", it), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_spi_hsctl.md
# sc_spi_hsctl

SYSCLK-domain handshake controller for the SPI protocol engine. It converts a single-cycle transfer request into a level clock-enable (CLKEN), which the engine synchronizer carries into SRCCLK. It tracks the synchronized engine busy flag (SPIBUSY_SYSCLK) to detect transfer completion and enforces an acknowledge timeout. A post-transfer guard interval lets the two-stage synchronizers settle before the next request.

## Interface
Parameters:
- ACK_TIMEOUT, 255: max SYSCLK cycles CLKEN is held waiting for busy to rise; legal 1..65535
- GUARD_CYCLES, 4: min SYSCLK cycles CLKEN is held low after a transfer; legal 1..65535

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge
- SYSRSTB  in  1  asynchronous active-low reset
- START  in  1  single-cycle transfer request; honoured only in IDLE
- ABORT  in  1  single-cycle abort request
- ERRCLR  in  1  clears TOUT_STS
- SPIBUSY_SYSCLK  in  1  engine busy, already synchronized to SYSCLK
- CLKEN  out  1  engine clock enable, level, registered
- BUSY  out  1  high whenever state is not IDLE
- DONE  out  1  one-cycle pulse at transfer end (normal or aborted after engine start)
- TIMEOUT  out  1  one-cycle pulse on acknowledge timeout
- TOUT_STS  out  1  sticky timeout status

## Operation
- One 16-bit counter CNT, shared by REQ and GUARD; cleared on every state entry.
- IDLE: CLKEN=0. Transitions:
  - START & !ABORT & !SPIBUSY_SYSCLK -> REQ.
  - START while SPIBUSY_SYSCLK=1 (stale busy) is ignored.
- REQ: CLKEN=1; CNT increments each cycle. Transitions:
  - SPIBUSY_SYSCLK=1 -> RUN; with ABORT in the same cycle -> STOP.
  - ABORT with busy=0 -> GUARD; no DONE, no TIMEOUT.
  - CNT==ACK_TIMEOUT-1 with busy=0 -> GUARD; pulse TIMEOUT; set TOUT_STS.
  - Busy rising in the timeout cycle wins -> RUN.
- RUN: CLKEN=1. Transitions:
  - SPIBUSY_SYSCLK=0 -> GUARD; pulse DONE.
  - ABORT -> STOP.
- STOP: CLKEN=0; wait for SPIBUSY_SYSCLK=0 -> GUARD; pulse DONE.
- GUARD: CLKEN=0. Transitions:
  - SPIBUSY_SYSCLK=1 reloads CNT to 0 (late busy rise after a timeout extends GUARD).
  - CNT==GUARD_CYCLES-1 with busy=0 -> IDLE.
- START outside IDLE is ignored and not queued.
- ERRCLR clears TOUT_STS. If ERRCLR and a timeout occur in the same cycle, set wins.

## Timing
- Reset values: state=IDLE, CNT=0, CLKEN=0, BUSY=0, DONE=0, TIMEOUT=0, TOUT_STS=0. Reset is asynchronous; asserting it mid-RUN drops CLKEN immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- START sampled at edge n -> CLKEN=1 and BUSY=1 from n+1.
- DONE and TIMEOUT go high in the first GUARD cycle, for exactly one cycle.
- Timeout case: CLKEN is high for exactly ACK_TIMEOUT cycles.
- GUARD lasts at least GUARD_CYCLES cycles. BUSY falls the cycle after the last GUARD cycle.
- Earliest next accepted START is the first IDLE cycle.

## Configuration
- SC_SPI_HSCTL_TIMEOUT_EN defined:
  - Acknowledge timeout is active as described.
- Not defined:
  - REQ waits indefinitely for busy or ABORT.
  - TIMEOUT and TOUT_STS are tied 0.
  - ERRCLR is ignored.
  - ACK_TIMEOUT is unused.

## Test plan
- Normal transfer (GUARD_CYCLES=4): START at cycle 0; SPIBUSY_SYSCLK rises at cycle 5 and falls at cycle 20.
  - CLKEN 1..20.
  - DONE at 21 only.
  - BUSY falls at 25.
- Timeout (ACK_TIMEOUT=8): START, busy held 0.
  - CLKEN high 8 cycles.
  - TIMEOUT pulse in the next cycle.
  - TOUT_STS=1 until ERRCLR.
  - Repeat with ERRCLR asserted in the timeout cycle -> TOUT_STS=1.
- Abort in RUN: ABORT at cycle 10 with busy=1.
  - CLKEN=0 from 11.
  - Busy falls at 15 -> DONE at 16.
  - Repeat with ABORT in REQ, busy=0 -> no DONE, no TIMEOUT.
- Boundaries:
  - START with busy stuck 1 in IDLE -> ignored, CLKEN stays 0.
  - START+ABORT together -> stays IDLE.
  - Busy rise in the timeout cycle -> RUN, no TIMEOUT.
  - Busy rising in GUARD -> GUARD extended until busy=0 plus 4 cycles.
- Reset: SYSRSTB low mid-RUN -> all outputs 0 asynchronously; after release, START works normally.
- Build without SC_SPI_HSCTL_TIMEOUT_EN: busy held 0 for 1000 cycles -> CLKEN stays 1, TIMEOUT never asserted.
